// File: rtl/codec_arb_pkg.sv
// Shared types and widths for the codec register arbiter: FSM state encoding,
// codec register bus widths and a saturating counter helper.
package codec_arb_pkg;

    localparam int CODEC_ADDR_W  = 8;
    localparam int CODEC_WDATA_W = 9;
    localparam int CODEC_RDATA_W = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ISSUE       = 3'd1,
        WAIT_ACCEPT = 3'd2,
        WAIT_DONE   = 3'd3,
        RESPOND     = 3'd4
    } arb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: picks the lowest requester index at or after
// the pointer (wrapping), and advances the pointer past the winner on grant_en.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic                 grant_en,
    output logic [$clog2(N)-1:0] grant,
    output logic                 found
);

    localparam int IDX_W  = $clog2(N);
    localparam int IDX_W1 = IDX_W + 1;
    localparam logic [IDX_W:0]   N_EXT   = IDX_W1'(N);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [IDX_W-1:0] ptr_r;
    logic [2*N-1:0]   req_dbl_s;
    logic [N-1:0]     rot_s;
    logic [IDX_W-1:0] off_s;
    logic [IDX_W:0]   sum_s;

    // Rotate requests so the pointer sits at bit 0, then take the first set bit.
    always_comb begin
        req_dbl_s = {req, req};
        rot_s     = N'(req_dbl_s >> ptr_r);
        off_s     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = IDX_W'(i);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = {1'b0, ptr_r} + {1'b0, off_s};
        if (sum_s >= N_EXT) begin
            grant = IDX_W'(sum_s - N_EXT);
        end else begin
            grant = sum_s[IDX_W-1:0];
        end
        found = |req;
    end

    // Pointer moves one past the granted index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= '0;
        end else if (grant_en) begin
            ptr_r <= (grant == IDX_LAST) ? '0 : grant + IDX_ONE;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/codec_reg_arbiter.sv
// Shares the codec controller register port among NUM_REQ requesters, one
// read or write per grant, with busy-handshake tracking, timeout and error reporting.
module codec_reg_arbiter
    import codec_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*CODEC_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*CODEC_WDATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [CODEC_RDATA_W-1:0]          rsp_rdata,
    output logic                              rsp_error,
    output logic                              codec_rd_en,
    output logic                              codec_wr_en,
    output logic [CODEC_ADDR_W-1:0]           codec_reg_addr,
    output logic [CODEC_WDATA_W-1:0]          codec_data_in,
    input  logic [CODEC_RDATA_W-1:0]          codec_data_out,
    input  logic                              codec_data_out_valid,
    input  logic                              controller_busy,
    input  logic                              missed_ack,
    output logic [15:0]                       timeout_count
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    arb_state_e               state_r;
    logic [IDX_W-1:0]         grant_r;
    logic                     write_r;
    logic                     err_r;
    logic [CODEC_RDATA_W-1:0] rdata_r;
    logic [TMR_W-1:0]         timer_r;

    logic [IDX_W-1:0]         arb_grant_s;
    logic                     arb_found_s;
    logic                     grant_en_s;
    logic                     sel_write_s;
    logic [CODEC_ADDR_W-1:0]  sel_addr_s;
    logic [CODEC_WDATA_W-1:0] sel_wdata_s;
    logic [NUM_REQ-1:0]       sel_onehot_s;
    logic [NUM_REQ-1:0]       grant_onehot_s;
    logic                     timer_hit_s;
    logic                     done_err_s;
    logic [CODEC_RDATA_W-1:0] done_data_s;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req_valid),
        .grant_en (grant_en_s),
        .grant    (arb_grant_s),
        .found    (arb_found_s)
    );

    // A grant is only taken from IDLE while the controller is not busy.
    always_comb begin
        grant_en_s = (state_r == IDLE) && !controller_busy && arb_found_s;
    end

    // Request field mux for the arbiter winner and one-hot forms of both grants.
    always_comb begin
        sel_write_s    = 1'b0;
        sel_addr_s     = '0;
        sel_wdata_s    = '0;
        sel_onehot_s   = '0;
        grant_onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant_s == IDX_W'(i)) begin
                sel_write_s     = req_write[i];
                sel_addr_s      = req_addr[i*CODEC_ADDR_W +: CODEC_ADDR_W];
                sel_wdata_s     = req_wdata[i*CODEC_WDATA_W +: CODEC_WDATA_W];
                sel_onehot_s[i] = 1'b1;
            end else begin
                sel_onehot_s[i] = 1'b0;
            end
            if (grant_r == IDX_W'(i)) begin
                grant_onehot_s[i] = 1'b1;
            end else begin
                grant_onehot_s[i] = 1'b0;
            end
        end
    end

    // Completion values: a missed ACK or read data in the final busy cycle still counts.
    always_comb begin
        timer_hit_s = (timer_r == TMR_LAST);
        done_err_s  = err_r | missed_ack;
        done_data_s = codec_data_out_valid ? codec_data_out : rdata_r;
    end

    // Transfer FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            grant_r        <= '0;
            write_r        <= 1'b0;
            err_r          <= 1'b0;
            rdata_r        <= '0;
            timer_r        <= '0;
            req_ready      <= '0;
            rsp_valid      <= '0;
            rsp_rdata      <= '0;
            rsp_error      <= 1'b0;
            codec_rd_en    <= 1'b0;
            codec_wr_en    <= 1'b0;
            codec_reg_addr <= '0;
            codec_data_in  <= '0;
            timeout_count  <= 16'd0;
        end else begin
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            codec_rd_en <= 1'b0;
            codec_wr_en <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_en_s) begin
                        grant_r        <= arb_grant_s;
                        write_r        <= sel_write_s;
                        err_r          <= 1'b0;
                        rdata_r        <= '0;
                        codec_reg_addr <= sel_addr_s;
                        codec_data_in  <= sel_wdata_s;
                        codec_rd_en    <= !sel_write_s;
                        codec_wr_en    <= sel_write_s;
                        req_ready      <= sel_onehot_s;
                        state_r        <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    timer_r <= '0;
                    state_r <= WAIT_ACCEPT;
                end
                WAIT_ACCEPT: begin
                    if (controller_busy) begin
                        timer_r <= '0;
                        state_r <= WAIT_DONE;
                    end else if (timer_hit_s) begin
                        rsp_valid     <= grant_onehot_s;
                        rsp_error     <= 1'b1;
                        timeout_count <= sat_inc16(timeout_count);
                        state_r       <= RESPOND;
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                WAIT_DONE: begin
                    rdata_r <= done_data_s;
                    err_r   <= done_err_s;
                    if (!controller_busy) begin
                        rsp_valid <= grant_onehot_s;
                        rsp_error <= done_err_s;
                        rsp_rdata <= (!write_r && !done_err_s) ? done_data_s : '0;
                        state_r   <= RESPOND;
                    end else if (timer_hit_s) begin
                        rsp_valid     <= grant_onehot_s;
                        rsp_error     <= 1'b1;
                        timeout_count <= sat_inc16(timeout_count);
                        state_r       <= RESPOND;
                    end else begin
                        timer_r <= timer_r + TMR_ONE;
                    end
                end
                RESPOND: begin
                    err_r   <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_codec_reg_arbiter.sv
// Scoreboard bench for codec_reg_arbiter: a behavioural controller model answers
// transfers, and expected responses are queued when requests are driven.
module tb_codec_reg_arbiter;

    typedef struct {
        int         idx;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [23:0] req_addr;
    logic [26:0] req_wdata;
    logic [7:0]  rsp_rdata, codec_reg_addr, codec_data_out;
    logic        rsp_error, codec_rd_en, codec_wr_en, codec_data_out_valid, missed_ack;
    logic [8:0]  codec_data_in;
    logic        controller_busy, init_busy, mdl_busy;
    logic [15:0] timeout_count;

    logic [2:0]  to_req_valid, to_req_write, to_req_ready, to_rsp_valid;
    logic [23:0] to_req_addr;
    logic [26:0] to_req_wdata;
    logic [7:0]  to_rsp_rdata, to_reg_addr, to_data_out;
    logic        to_rsp_error, to_rd_en, to_wr_en, to_data_out_valid, to_busy, to_missed;
    logic [8:0]  to_data_in;
    logic [15:0] to_timeout_count;

    int   mdl_cycles = 20;
    bit   mdl_missed = 1'b0;
    exp_t sb_q[$];
    exp_t e;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    assign controller_busy = init_busy | mdl_busy;

    always #5 clk = ~clk;

    codec_reg_arbiter dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en),
        .codec_reg_addr(codec_reg_addr), .codec_data_in(codec_data_in),
        .codec_data_out(codec_data_out), .codec_data_out_valid(codec_data_out_valid),
        .controller_busy(controller_busy), .missed_ack(missed_ack),
        .timeout_count(timeout_count)
    );

    codec_reg_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .reset_n(reset_n), .req_valid(to_req_valid), .req_write(to_req_write),
        .req_addr(to_req_addr), .req_wdata(to_req_wdata), .req_ready(to_req_ready),
        .rsp_valid(to_rsp_valid), .rsp_rdata(to_rsp_rdata), .rsp_error(to_rsp_error),
        .codec_rd_en(to_rd_en), .codec_wr_en(to_wr_en),
        .codec_reg_addr(to_reg_addr), .codec_data_in(to_data_in),
        .codec_data_out(to_data_out), .codec_data_out_valid(to_data_out_valid),
        .controller_busy(to_busy), .missed_ack(to_missed),
        .timeout_count(to_timeout_count)
    );

    // Controller model: busy for mdl_cycles after a rd/wr pulse; read data = addr ^ 8'hA0.
    initial begin : controller_model
        logic       lat_rd;
        logic [7:0] lat_addr;
        mdl_busy = 1'b0;
        codec_data_out = 8'h00;
        codec_data_out_valid = 1'b0;
        missed_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && (codec_rd_en || codec_wr_en)) begin
                lat_rd   = codec_rd_en;
                lat_addr = codec_reg_addr;
                mdl_busy = 1'b1;
                for (int k = 0; k < mdl_cycles; k++) begin
                    codec_data_out_valid = lat_rd && (k == mdl_cycles - 1);
                    codec_data_out = (lat_rd && (k == mdl_cycles - 1)) ? (lat_addr ^ 8'hA0) : 8'h00;
                    missed_ack = mdl_missed && (k == 5);
                    @(negedge clk);
                end
                mdl_busy = 1'b0;
                codec_data_out_valid = 1'b0;
                codec_data_out = 8'h00;
                missed_ack = 1'b0;
            end
        end
    end

    task automatic wait_ready(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (|req_ready) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (|rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        init_busy = 1'b0;
        req_valid = 3'b000; req_write = 3'b000; req_addr = 24'h0; req_wdata = 27'h0;
        to_req_valid = 3'b000; to_req_write = 3'b000; to_req_addr = 24'h0; to_req_wdata = 27'h0;
        to_data_out = 8'h00; to_data_out_valid = 1'b0; to_busy = 1'b0; to_missed = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_error, codec_rd_en, codec_wr_en,
             codec_reg_addr, codec_data_in, timeout_count} !== 60'h0)
            $display("FAIL reset_outputs: got nonzero outputs (addr %h ready %b) expected all 0",
                     codec_reg_addr, req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({to_req_ready, to_rsp_valid, to_timeout_count} !== 22'h0)
            $display("FAIL reset_outputs_to: got %h expected 0",
                     {to_req_ready, to_rsp_valid, to_timeout_count});
        else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_init_hold();
        int viol = 0;
        bit got;
        init_busy = 1'b1;
        mdl_cycles = 4;
        req_valid = 3'b001; req_write = 3'b001;
        req_addr[7:0] = 8'h10; req_wdata[8:0] = 9'h1AB;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (req_ready !== 3'b000 || codec_rd_en !== 1'b0 || codec_wr_en !== 1'b0) viol++;
        end
        total_cnt++;
        if (viol !== 0) $display("FAIL init_hold: got %0d grant cycles while busy, expected 0", viol);
        else pass_cnt++;
        init_busy = 1'b0;
        sb_q.push_back('{idx: 0, rdata: 8'h00, err: 1'b0});
        @(negedge clk);
        total_cnt++;
        if (req_ready !== 3'b001) $display("FAIL init_release_ready: got %b expected 001", req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({codec_wr_en, codec_rd_en, codec_reg_addr, codec_data_in} !== {1'b1, 1'b0, 8'h10, 9'h1AB})
            $display("FAIL init_write_issue: got wr %b rd %b addr %h data %h expected 1 0 10 1ab",
                     codec_wr_en, codec_rd_en, codec_reg_addr, codec_data_in);
        else pass_cnt++;
        req_valid = 3'b000;
        wait_rsp(50, got);
        e = sb_q.pop_front();
        total_cnt++;
        if (!got || rsp_valid !== (3'b001 << e.idx) || rsp_rdata !== e.rdata || rsp_error !== e.err)
            $display("FAIL init_write_rsp: got valid %b rdata %h err %b expected %b %h %b",
                     rsp_valid, rsp_rdata, rsp_error, 3'b001 << e.idx, e.rdata, e.err);
        else pass_cnt++;
    endtask

    task automatic test_read();
        bit got;
        mdl_cycles = 20;
        req_valid = 3'b010; req_write = 3'b000; req_addr[15:8] = 8'h05;
        sb_q.push_back('{idx: 1, rdata: 8'hA5, err: 1'b0});
        wait_ready(20, got);
        total_cnt++;
        if (!got || req_ready !== 3'b010 || codec_rd_en !== 1'b1 || codec_reg_addr !== 8'h05)
            $display("FAIL read_issue: got ready %b rd %b addr %h expected 010 1 05",
                     req_ready, codec_rd_en, codec_reg_addr);
        else pass_cnt++;
        req_valid = 3'b000;
        wait_rsp(60, got);
        e = sb_q.pop_front();
        total_cnt++;
        if (!got || rsp_valid !== (3'b001 << e.idx)) $display("FAIL read_rsp_valid: got %b expected 010", rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (rsp_rdata !== e.rdata) $display("FAIL read_rdata: got %h expected %h", rsp_rdata, e.rdata);
        else pass_cnt++;
        total_cnt++;
        if (rsp_error !== e.err) $display("FAIL read_error: got %b expected %b", rsp_error, e.err);
        else pass_cnt++;
    endtask

    task automatic test_missed_ack();
        bit got;
        mdl_cycles = 10;
        mdl_missed = 1'b1;
        req_valid = 3'b100; req_write = 3'b100; req_addr[23:16] = 8'h2A; req_wdata[26:18] = 9'h0F0;
        sb_q.push_back('{idx: 2, rdata: 8'h00, err: 1'b1});
        wait_ready(20, got);
        total_cnt++;
        if (!got || req_ready !== 3'b100) $display("FAIL ack_ready: got %b expected 100", req_ready);
        else pass_cnt++;
        req_valid = 3'b000;
        wait_rsp(40, got);
        e = sb_q.pop_front();
        total_cnt++;
        if (!got || rsp_valid !== (3'b001 << e.idx) || rsp_rdata !== e.rdata || rsp_error !== e.err)
            $display("FAIL ack_rsp: got valid %b rdata %h err %b expected %b %h %b",
                     rsp_valid, rsp_rdata, rsp_error, 3'b001 << e.idx, e.rdata, e.err);
        else pass_cnt++;
        total_cnt++;
        if (timeout_count !== 16'd0) $display("FAIL ack_no_timeout_count: got %0d expected 0", timeout_count);
        else pass_cnt++;
        mdl_missed = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        bit got;
        mdl_cycles = 3;
        req_addr = {8'h22, 8'h21, 8'h20};
        req_write = 3'b000;
        for (int t = 0; t < 6; t++) sb_q.push_back('{idx: t % 3, rdata: (8'h20 + 8'(t % 3)) ^ 8'hA0, err: 1'b0});
        req_valid = 3'b111;
        for (int t = 0; t < 6; t++) begin
            wait_ready(40, got);
            total_cnt++;
            if (!got || req_ready !== (3'b001 << sb_q[0].idx))
                $display("FAIL rr_grant_%0d: got %b expected %b", t, req_ready, 3'b001 << sb_q[0].idx);
            else pass_cnt++;
            if (t == 5) req_valid = 3'b000;
            wait_rsp(40, got);
            e = sb_q.pop_front();
            total_cnt++;
            if (!got || rsp_valid !== (3'b001 << e.idx) || rsp_rdata !== e.rdata || rsp_error !== e.err)
                $display("FAIL rr_rsp_%0d: got valid %b rdata %h err %b expected %b %h %b",
                         t, rsp_valid, rsp_rdata, rsp_error, 3'b001 << e.idx, e.rdata, e.err);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_op();
        bit got;
        int stale = 0;
        int extra = 0;
        mdl_cycles = 20;
        req_valid = 3'b001; req_write = 3'b000; req_addr[7:0] = 8'h3C;
        wait_ready(20, got);
        req_valid = 3'b000;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_error, codec_rd_en, codec_wr_en,
             codec_reg_addr, codec_data_in, timeout_count} !== 60'h0)
            $display("FAIL async_reset: got addr %h rd %b expected all outputs 0", codec_reg_addr, codec_rd_en);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        req_addr = {8'h00, 8'h55, 8'h44};
        req_valid = 3'b011;
        sb_q.push_back('{idx: 0, rdata: 8'h44 ^ 8'hA0, err: 1'b0});
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (|rsp_valid) stale++;
            if (|req_ready) begin
                got = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!got || req_ready !== 3'b001) $display("FAIL post_reset_grant: got %b expected 001", req_ready);
        else pass_cnt++;
        total_cnt++;
        if (stale !== 0) $display("FAIL lost_transfer_rsp: got %0d responses expected 0", stale);
        else pass_cnt++;
        req_valid = 3'b000;
        wait_rsp(60, got);
        e = sb_q.pop_front();
        total_cnt++;
        if (!got || rsp_valid !== (3'b001 << e.idx) || rsp_rdata !== e.rdata || rsp_error !== e.err)
            $display("FAIL post_reset_rsp: got valid %b rdata %h err %b expected %b %h %b",
                     rsp_valid, rsp_rdata, rsp_error, 3'b001 << e.idx, e.rdata, e.err);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (|req_ready) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL dropped_req_granted: got %0d grants expected 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit got = 1'b0;
        int cyc = 0;
        to_req_valid = 3'b001; to_req_write = 3'b000; to_req_addr[7:0] = 8'h77;
        sb_q.push_back('{idx: 0, rdata: 8'h00, err: 1'b1});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (|to_req_ready) begin
                got = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (!got || to_req_ready !== 3'b001) $display("FAIL timeout_ready: got %b expected 001", to_req_ready);
        else pass_cnt++;
        to_req_valid = 3'b000;
        got = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (|to_rsp_valid) begin
                got = 1'b1;
                cyc = i;
                break;
            end
        end
        e = sb_q.pop_front();
        total_cnt++;
        if (!got || cyc !== 17) $display("FAIL timeout_latency: got %0d cycles after ready expected 17", cyc);
        else pass_cnt++;
        total_cnt++;
        if (to_rsp_valid !== (3'b001 << e.idx) || to_rsp_error !== e.err || to_rsp_rdata !== e.rdata)
            $display("FAIL timeout_rsp: got valid %b err %b rdata %h expected %b %b %h",
                     to_rsp_valid, to_rsp_error, to_rsp_rdata, 3'b001 << e.idx, e.err, e.rdata);
        else pass_cnt++;
        total_cnt++;
        if (to_timeout_count !== 16'd1) $display("FAIL timeout_count: got %0d expected 1", to_timeout_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_init_hold();
        test_read();
        test_missed_ack();
        test_round_robin();
        test_reset_mid_op();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
